// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer for the fetch and data ports.
// Optional starvation guard for fetch: define ARB_FAIRNESS_EN.
module mem_arbiter #(
   parameter int WIDTH    = 32,
   parameter int ADDR_LEN = 32,
   parameter int MEM_AW   = 6,
   parameter int LAT      = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_LEN-1:0] if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [WIDTH-1:0]    if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_LEN-1:0] dm_addr,
   input  logic [WIDTH-1:0]    dm_wdata,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [WIDTH-1:0]    dm_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic [WIDTH-1:0]    mem_rdata,
   output logic                busy
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        store_q, store_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        force_if;
   logic        dm_win, if_win;

   logic              if_gnt_c, dm_gnt_c;
   logic              if_rvalid_c, dm_rvalid_c;
   logic [WIDTH-1:0]  if_rdata_c, dm_rdata_c;
   logic              mem_en_c, mem_we_c;
   logic [MEM_AW-1:0] mem_addr_c;
   logic [WIDTH-1:0]  mem_wdata_c;

`ifdef ARB_FAIRNESS_EN
   logic [3:0] starve_q, starve_d;

   assign force_if = (starve_q == 4'(MAX_WAIT));

   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (if_win)
            starve_d = 4'd0;
         else if (if_req)
            starve_d = (starve_q == 4'hf) ? starve_q : starve_q + 4'd1;
         else
            starve_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         starve_q <= 4'd0;
      else
         starve_q <= starve_d;
   end
`else
   // Strict priority: fetch is never forced ahead of data.
   assign force_if = (MAX_WAIT == 0);
`endif

   assign dm_win = dm_req & ~(if_req & force_if);
   assign if_win = if_req & ~dm_win;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      store_d     = store_q;
      cnt_d       = cnt_q;
      if_gnt_c    = 1'b0;
      dm_gnt_c    = 1'b0;
      if_rvalid_c = 1'b0;
      dm_rvalid_c = 1'b0;
      if_rdata_c  = '0;
      dm_rdata_c  = '0;
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      unique case (state_q)
         IDLE: begin
            if (dm_win) begin
               dm_gnt_c    = 1'b1;
               mem_en_c    = 1'b1;
               mem_we_c    = dm_we;
               mem_addr_c  = dm_addr[MEM_AW+1:2];
               mem_wdata_c = dm_we ? dm_wdata : '0;
               owner_d     = 1'b1;
               store_d     = dm_we;
               cnt_d       = 4'(LAT - 1);
               state_d     = WAIT;
            end else if (if_win) begin
               if_gnt_c   = 1'b1;
               mem_en_c   = 1'b1;
               mem_addr_c = if_addr[MEM_AW+1:2];
               owner_d    = 1'b0;
               store_d    = 1'b0;
               cnt_d      = 4'(LAT - 1);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
               if (owner_q) begin
                  dm_rvalid_c = 1'b1;
                  dm_rdata_c  = store_q ? '0 : mem_rdata;
               end else begin
                  if_rvalid_c = 1'b1;
                  if_rdata_c  = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         store_q <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         store_q <= store_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset forces every output low immediately, even with requests held.
   assign if_gnt    = reset & if_gnt_c;
   assign dm_gnt    = reset & dm_gnt_c;
   assign if_rvalid = reset & if_rvalid_c;
   assign dm_rvalid = reset & dm_rvalid_c;
   assign if_rdata  = {WIDTH{reset}} & if_rdata_c;
   assign dm_rdata  = {WIDTH{reset}} & dm_rdata_c;
   assign mem_en    = reset & mem_en_c;
   assign mem_we    = reset & mem_we_c;
   assign mem_addr  = {MEM_AW{reset}} & mem_addr_c;
   assign mem_wdata = {WIDTH{reset}} & mem_wdata_c;
   assign busy      = reset & (state_q == WAIT);

   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[ADDR_LEN-1:MEM_AW+2], if_addr[1:0],
                               dm_addr[ADDR_LEN-1:MEM_AW+2], dm_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle model plus directed literal checks.
// Also checks a LAT=1 instance for back-to-back throughput.
module tb_mem_arbiter;

   localparam int W   = 32;
   localparam int AL  = 32;
   localparam int MAW = 6;
   localparam int LAT = 2;
   localparam int MW  = 3;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [AL-1:0] if_addr = '0;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AL-1:0] dm_addr = '0;
   logic [W-1:0]  dm_wdata = '0;
   logic [W-1:0]  mem_rdata = '0;

   logic           if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   logic           mem_en, mem_we, busy;
   logic [W-1:0]   if_rdata, dm_rdata, mem_wdata;
   logic [MAW-1:0] mem_addr;

   logic           d1_if_gnt, d1_if_rvalid, d1_dm_gnt, d1_dm_rvalid;
   logic           d1_mem_en, d1_mem_we, d1_busy;
   logic [W-1:0]   d1_if_rdata, d1_dm_rdata, d1_mem_wdata;
   logic [MAW-1:0] d1_mem_addr;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WIDTH(W), .ADDR_LEN(AL), .MEM_AW(MAW), .LAT(LAT),
                 .MAX_WAIT(MW)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_arbiter #(.WIDTH(W), .ADDR_LEN(AL), .MEM_AW(MAW), .LAT(1),
                 .MAX_WAIT(MW)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(d1_if_gnt),
      .if_rvalid(d1_if_rvalid), .if_rdata(d1_if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(d1_dm_gnt), .dm_rvalid(d1_dm_rvalid),
      .dm_rdata(d1_dm_rdata), .mem_en(d1_mem_en), .mem_we(d1_mem_we),
      .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
      .mem_rdata(mem_rdata), .busy(d1_busy));

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   // Cycle model: one access at a time, done LAT cycles after its grant.
   bit m_busy = 0;
   bit m_dm = 0;
   bit m_store = 0;
   int m_done = 0;
   int m_starve = 0;

   initial begin
      forever begin
         logic           e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy;
         logic [W-1:0]   e_ird, e_drd, e_wd;
         logic [MAW-1:0] e_ad;
         bit             take_if;
         @(negedge clk);
         {e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy} = '0;
         e_ird = '0; e_drd = '0; e_wd = '0; e_ad = '0;
         if (!reset) begin
            m_busy = 0;
            m_starve = 0;
         end else if (m_busy) begin
            e_busy = 1'b1;
            if (cyc == m_done) begin
               m_busy = 0;
               if (m_dm) begin
                  e_dv = 1'b1;
                  e_drd = m_store ? '0 : mem_rdata;
               end else begin
                  e_iv = 1'b1;
                  e_ird = mem_rdata;
               end
            end
         end else if (if_req || dm_req) begin
            take_if = if_req && (!dm_req || (FAIR && m_starve >= MW));
            if (take_if) m_starve = 0;
            else if (if_req) m_starve = m_starve + 1;
            else m_starve = 0;
            e_en = 1'b1;
            m_busy = 1;
            m_done = cyc + LAT;
            m_dm = !take_if;
            if (take_if) begin
               e_ig = 1'b1;
               e_ad = MAW'(if_addr >> 2);
               m_store = 0;
            end else begin
               e_dg = 1'b1;
               e_ad = MAW'(dm_addr >> 2);
               e_we = dm_we;
               e_wd = dm_we ? dm_wdata : '0;
               m_store = dm_we;
            end
         end else begin
            m_starve = 0;
         end
         chk("if_gnt", 32'(if_gnt), 32'(e_ig));
         chk("dm_gnt", 32'(dm_gnt), 32'(e_dg));
         chk("if_rvalid", 32'(if_rvalid), 32'(e_iv));
         chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dv));
         chk("if_rdata", if_rdata, e_ird);
         chk("dm_rdata", dm_rdata, e_drd);
         chk("mem_en", 32'(mem_en), 32'(e_en));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_addr", 32'(mem_addr), 32'(e_ad));
         chk("mem_wdata", mem_wdata, e_wd);
         chk("busy", 32'(busy), 32'(e_busy));
         cyc++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if_req = 1'b0;
         dm_req = 1'b0;
      end
   endtask

   initial begin
      tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      tick();
      reset = 1'b1;
      idle(2);

      // single fetch
      tick();
      if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("sf_gnt", 32'(if_gnt), 32'd1);
      chk("sf_en", 32'(mem_en), 32'd1);
      chk("sf_addr", 32'(mem_addr), 32'd4);
      tick();
      if_req = 1'b0;
      @(negedge clk);
      chk("sf_busy1", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      chk("sf_rvalid", 32'(if_rvalid), 32'd1);
      chk("sf_rdata", if_rdata, 32'hDEADBEEF);
      chk("sf_busy2", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      chk("sf_busy3", 32'(busy), 32'd0);

      // store then load
      tick();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'h55;
      @(negedge clk);
      chk("st_gnt", 32'(dm_gnt), 32'd1);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_addr", 32'(mem_addr), 32'd2);
      chk("st_wdata", mem_wdata, 32'h55);
      tick();
      dm_we = 1'b0; dm_wdata = '0;
      @(negedge clk);
      chk("ld_wait1", 32'(dm_gnt), 32'd0);
      tick();
      @(negedge clk);
      chk("st_rvalid", 32'(dm_rvalid), 32'd1);
      chk("st_rdata", dm_rdata, 32'd0);
      chk("ld_wait2", 32'(dm_gnt), 32'd0);
      tick();
      @(negedge clk);
      chk("ld_gnt3", 32'(dm_gnt), 32'd1);
      chk("ld_we", 32'(mem_we), 32'd0);
      tick();
      dm_req = 1'b0; mem_rdata = 32'h12345678;
      tick();
      @(negedge clk);
      chk("ld_rdata", dm_rdata, 32'h12345678);
      idle(2);

      // conflict
      tick();
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_addr = 32'h20; mem_rdata = 32'hA5A5_0001;
      @(negedge clk);
      chk("cf_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("cf_if_gnt", 32'(if_gnt), 32'd0);
      chk("cf_addr", 32'(mem_addr), 32'd8);
      tick();
      dm_req = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("cf_if_gnt3", 32'(if_gnt), 32'd1);
      chk("cf_addr3", 32'(mem_addr), 32'd16);
      idle(4);

      // starvation: both held high
      tick();
      if_req = 1'b1; if_addr = 32'h4;
      dm_req = 1'b1; dm_addr = 32'h3C;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         chk($sformatf("sv_dm%0d", c), 32'(dm_gnt),
             32'((c % 3 == 0) && !(FAIR && c == 9)));
         chk($sformatf("sv_if%0d", c), 32'(if_gnt),
             32'(FAIR && c == 9));
      end
      idle(4);

      // reset mid-access
      tick();
      dm_req = 1'b1; dm_addr = 32'h4;
      @(negedge clk);
      chk("ra_gnt", 32'(dm_gnt), 32'd1);
      tick();
      dm_req = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("ra_busy", 32'(busy), 32'd0);
      chk("ra_en", 32'(mem_en), 32'd0);
      tick();
      @(negedge clk);
      chk("ra_norv", 32'(dm_rvalid), 32'd0);
      tick();
      reset = 1'b1; if_req = 1'b1; if_addr = 32'h0C;
      @(negedge clk);
      chk("ra_regnt", 32'(if_gnt), 32'd1);
      chk("ra_addr", 32'(mem_addr), 32'd3);
      idle(5);

      // LAT=1 back-to-back loads on the second instance
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30; mem_rdata = 32'h0BAD_F00D;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         chk($sformatf("l1_gnt%0d", c), 32'(d1_dm_gnt), 32'(c % 2 == 0));
         chk($sformatf("l1_rv%0d", c), 32'(d1_dm_rvalid), 32'(c % 2 == 1));
      end
      chk("l1_rdata", d1_dm_rdata, 32'h0BAD_F00D);
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for a single-ported unified memory shared by the fetch stage (instruction port) and the memory-access stage (data port) of the in-order pipeline. Accepts one request per arbitration, drives the memory for one cycle, tracks a fixed read latency, and returns data to the owning port. Unstalled port gets `gnt`; the denied port's `req` low-to-`gnt` gap drives the pipeline stall logic.

## Interface
Parameters:
- `WIDTH`, 32, data width
- `ADDR_LEN`, 32, byte-address width of both request ports
- `MEM_AW`, 6, memory word-address width
- `LAT`, 2, memory read latency in cycles, legal range 1..15
- `MAX_WAIT`, 3, starvation bound for the instruction port, legal range 1..15; used only with `ARB_FAIRNESS_EN`

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  instruction read request
- `if_addr`  in  ADDR_LEN  instruction byte address
- `if_gnt`  out  1  instruction request accepted this cycle
- `if_rvalid`  out  1  instruction data valid
- `if_rdata`  out  WIDTH  instruction data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_LEN  data byte address
- `dm_wdata`  in  WIDTH  store data
- `dm_gnt`  out  1  data request accepted this cycle
- `dm_rvalid`  out  1  load data valid / store complete
- `dm_rdata`  out  WIDTH  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  MEM_AW  word address = selected byte address[MEM_AW+1:2]
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  memory read data
- `busy`  out  1  access outstanding

## Operation
- States: IDLE and WAIT. The owner register is 0 for IF and 1 for DM. The 4-bit `cnt` register is the latency counter.
- IDLE, any request pending:
  - Select the winner and assert its `gnt`.
  - Drive `mem_en`=1, plus `mem_addr`/`mem_we`/`mem_wdata` from the winner, all combinationally.
  - Latch owner, load `cnt`=LAT-1, go to WAIT.
- IDLE, no request: all strobes 0.
- WAIT:
  - `busy`=1. Both `gnt` are 0 and `mem_en`=0.
  - When `cnt`==0: assert the owner's `rvalid` and return to IDLE. Otherwise decrement `cnt`.
  - For loads and instruction fetches, `rdata` = `mem_rdata` on the `rvalid` cycle.
  - For stores, `dm_rdata` = 0.
  - `rdata` is 0 whenever `rvalid` is 0.
- Default priority: DM beats IF (strict).
- Requesters hold `req`, `addr`, `we` and `wdata` stable until `gnt`. They may change them the cycle after `gnt`.
- A request arriving while in WAIT is not seen until IDLE. There is no queueing.
- `mem_wdata` = 0 unless a store is granted.
- Reset (`reset`=0, any time, including mid-WAIT):
  - State goes to IDLE, with `cnt`=0, owner=0 and the starvation counter at 0.
  - All outputs are 0. An outstanding access is dropped and no `rvalid` is issued for it.

## Timing
- Grant at cycle N (combinational from `req` in IDLE). The memory samples at the end of N.
- `rvalid` is asserted in cycle N+LAT. IDLE is re-entered at N+LAT+1, so the earliest next grant is N+LAT+1.
- Throughput: one access per LAT+1 cycles.
- Simultaneous `if_req` and `dm_req` in IDLE resolve by the priority rule. The loser's `gnt` stays 0 and it retries every IDLE cycle.
- `rvalid` and `gnt` are never high in the same cycle.

## Configuration
- Macro `ARB_FAIRNESS_EN`, defined: adds a 4-bit starvation counter.
  - Increment on each IDLE arbitration where `if_req`=1 but DM wins.
  - When the counter equals MAX_WAIT, the next IDLE arbitration with `if_req`=1 grants IF even if `dm_req`=1.
  - Clear the counter on any IF grant, or when `if_req`=0 in IDLE.
- Macro undefined: strict DM priority. IF can starve indefinitely and there is no counter logic.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x10 at cycle 0, LAT=2. Expect `if_gnt` and `mem_en` at cycle 0 with `mem_addr`=4. Drive `mem_rdata`=0xDEADBEEF. Expect `if_rvalid`=1 at cycle 2 with `if_rdata`=0xDEADBEEF, and `busy` high in cycles 1–2.
- Store then load:
  - Store `dm_addr`=0x8, `dm_wdata`=0x55 → `mem_we`=1, `mem_addr`=2, `dm_rvalid` at cycle 2 with `dm_rdata`=0.
  - Load the same address: earliest grant at cycle 3.
- Conflict: `if_req`=`dm_req`=1 at cycle 0 → `dm_gnt`=1, `if_gnt`=0. IF is granted at cycle 3 once `dm_req` drops.
- Starvation (`ARB_FAIRNESS_EN`, MAX_WAIT=3): hold both requests high.
  - Expect DM granted at cycles 0, 3 and 6, then IF at cycle 9, then DM at cycle 12.
  - Without the macro, IF is never granted.
- Reset mid-access: pull `reset` low at cycle 1 after a grant at cycle 0. Expect all outputs 0 immediately and no `rvalid`. After release, a fresh request is granted in the first IDLE cycle.
- LAT=1: back-to-back DM loads → grants at cycles 0, 2 and 4, with `rvalid` at cycles 1, 3 and 5.
